// File: rtl/prbs_gen_param.sv
// Multi-polynomial PRBS generator, DATA_W bits per beat on a valid/ready stream.
// Optional error injection is built when PRBS_ERR_INJECT_EN is defined.
module prbs_gen_param #(
  parameter int          DATA_W       = 8,
  parameter logic [30:0] DEFAULT_SEED = 31'h7FFF_FFFF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [2:0]        mode,
  input  logic              seed_load,
  input  logic [30:0]       seed,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              mode_err
`ifdef PRBS_ERR_INJECT_EN
  ,
  input  logic              err_inject,
  output logic [15:0]       err_count,
  output logic              err_pending
`endif
);

  function automatic logic [30:0] nmask_of(input logic [2:0] m);
    logic [30:0] r;
    unique case (m)
      3'd0:    r = 31'h0000_007F;
      3'd1:    r = 31'h0000_01FF;
      3'd2:    r = 31'h0000_1FFF;
      3'd3:    r = 31'h0000_7FFF;
      3'd4:    r = 31'h007F_FFFF;
      default: r = 31'h7FFF_FFFF;
    endcase
    return r;
  endfunction

  // Tap bit e-1 for every non-constant exponent e of the polynomial
  function automatic logic [30:0] taps_of(input logic [2:0] m);
    logic [30:0] r;
    unique case (m)
      3'd0:    r = 31'h0000_0060;
      3'd1:    r = 31'h0000_0110;
      3'd2:    r = 31'h0000_1803;
      3'd3:    r = 31'h0000_6000;
      3'd4:    r = 31'h0042_0000;
      default: r = 31'h4800_0000;
    endcase
    return r;
  endfunction

  logic [30:0]       state;
  logic [2:0]        mode_reg;
  logic [30:0]       nxt_state;
  logic [DATA_W-1:0] nxt_data;
  logic [DATA_W-1:0] flip;
  logic [30:0]       ld_mask;
  logic [30:0]       ld_seed;
  logic              free;
  logic              go;

  assign free    = !out_valid || out_ready;
  assign go      = enable && free;
  assign ld_mask = nmask_of(mode);
  assign ld_seed = ((seed & ld_mask) == 31'd0) ? ld_mask
                                                : (seed & ld_mask);

  always_comb begin
    logic [30:0] s;
    logic [30:0] tap;
    logic [30:0] msk;
    logic        f;
    s        = state;
    tap      = taps_of(mode_reg);
    msk      = nmask_of(mode_reg);
    nxt_data = '0;
    for (int i = 0; i < DATA_W; i++) begin
      f = ^(s & tap);
      s = ((s << 1) | {30'd0, f}) & msk;
      nxt_data[DATA_W-1-i] = f;
    end
    nxt_state = s;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= DEFAULT_SEED & ld_mask;
      mode_reg  <= mode;
      mode_err  <= (mode >= 3'd6);
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (seed_load) begin
      state     <= ld_seed;
      mode_reg  <= mode;
      mode_err  <= (mode >= 3'd6);
      out_valid <= 1'b0;
    end else if (free) begin
      if (enable) begin
        state     <= nxt_state;
        out_data  <= nxt_data ^ flip;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef PRBS_ERR_INJECT_EN
  always_comb begin
    flip           = '0;
    flip[DATA_W-1] = err_pending;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_pending <= 1'b0;
      err_count   <= 16'd0;
    end else if (seed_load) begin
      err_pending <= 1'b0;
    end else begin
      err_pending <= (err_pending && !go) || err_inject;
      if (go && err_pending && err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;
    end
  end
`else
  assign flip = '0;
`endif

endmodule

// File: tb/tb_prbs_gen_param.sv
// Randomised bench for prbs_gen_param against a bit-history recurrence model.
// Literal beat values pin both the model and the DUT.
module tb_prbs_gen_param;
  localparam int          DW   = 8;
  localparam logic [30:0] DSEED = 31'h7FFF_FFFF;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [2:0]    mode = 3'd0;
  logic          seed_load = 1'b0;
  logic [30:0]   seed = 31'd0;
  logic          out_ready = 1'b1;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          mode_err;
`ifdef PRBS_ERR_INJECT_EN
  logic          err_inject = 1'b0;
  logic [15:0]   err_count;
  logic          err_pending;
`endif

  prbs_gen_param #(.DATA_W(DW), .DEFAULT_SEED(DSEED)) dut (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode),
    .seed_load(seed_load), .seed(seed), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .mode_err(mode_err)
`ifdef PRBS_ERR_INJECT_EN
    , .err_inject(err_inject), .err_count(err_count),
    .err_pending(err_pending)
`endif
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Model: hist[i] is the serial bit produced i+1 steps ago
  bit            hist[$];
  int            m_mode;
  bit            e_valid;
  logic [DW-1:0] e_data;
  bit            e_err;
  bit            m_new;
  bit            m_pend;
  int            m_cnt;
  logic [DW-1:0] seen[$];

  function automatic int order_of(input int md);
    case (md)
      0: return 7;
      1: return 9;
      2: return 13;
      3: return 15;
      4: return 23;
      default: return 31;
    endcase
  endfunction

  function automatic void m_load(input logic [30:0] sv, input int md,
                                 input bit fix);
    bit allz = 1;
    m_mode = md;
    hist.delete();
    for (int i = 0; i < order_of(md); i++) begin
      hist.push_back(sv[i]);
      if (sv[i]) allz = 0;
    end
    if (fix && allz)
      for (int i = 0; i < hist.size(); i++) hist[i] = 1;
  endfunction

  function automatic bit m_step();
    int e[4];
    int ne;
    bit f = 0;
    case (m_mode)
      0: begin e = '{7, 6, 0, 0}; ne = 2; end
      1: begin e = '{9, 5, 0, 0}; ne = 2; end
      2: begin e = '{13, 12, 2, 1}; ne = 4; end
      3: begin e = '{15, 14, 0, 0}; ne = 2; end
      4: begin e = '{23, 18, 0, 0}; ne = 2; end
      default: begin e = '{31, 28, 0, 0}; ne = 2; end
    endcase
    for (int k = 0; k < ne; k++) f ^= hist[e[k]-1];
    hist.push_front(f);
    void'(hist.pop_back());
    return f;
  endfunction

  function automatic logic [30:0] m_state();
    logic [30:0] st = '0;
    for (int i = 0; i < hist.size(); i++) st[i] = hist[i];
    return st;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] a,
                              input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endfunction

  task automatic model_update();
    bit inj = 0;
`ifdef PRBS_ERR_INJECT_EN
    inj = err_inject;
`endif
    m_new = 0;
    if (reset) begin
      m_load(DSEED, int'(mode), 0);
      e_valid = 0; e_data = '0; e_err = (mode >= 6);
      m_pend = 0; m_cnt = 0;
    end else if (seed_load) begin
      m_load(seed, int'(mode), 1);
      e_valid = 0; e_err = (mode >= 6); m_pend = 0;
    end else begin
      bit go = 0;
      if (!e_valid || out_ready) begin
        if (enable) begin
          logic [DW-1:0] d = '0;
          for (int j = 0; j < DW; j++) d = {d[DW-2:0], m_step()};
          if (m_pend) begin
            d[DW-1] = ~d[DW-1];
            if (m_cnt < 65535) m_cnt++;
          end
          e_data = d; e_valid = 1; m_new = 1; go = 1;
        end else e_valid = 0;
      end
      m_pend = (m_pend && !go) || inj;
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    model_update();
    @(negedge clock);
    chk("out_valid", {31'd0, out_valid}, {31'd0, e_valid});
    chk("out_data", 32'(out_data), 32'(e_data));
    chk("mode_err", {31'd0, mode_err}, {31'd0, e_err});
`ifdef PRBS_ERR_INJECT_EN
    chk("err_count", {16'd0, err_count}, 32'(m_cnt));
    chk("err_pending", {31'd0, err_pending}, {31'd0, m_pend});
`endif
    if (m_new && out_valid) seen.push_back(out_data);
  endtask

  initial begin
    logic [15:0] bits;
    int nz;

    // Pin the model: PRBS7 from all-ones, then full period over 127 beats
    m_load(31'h7F, 0, 1);
    bits = '0;
    for (int i = 0; i < 16; i++) bits = {bits[14:0], m_step()};
    chk("model_prbs7_16b", 32'(bits), 32'h020C);
    for (int i = 16; i < 127 * 8; i++) void'(m_step());
    chk("model_prbs7_period", 32'(m_state()), 32'h7F);

    // PRBS7 from reset, period over 127 beats of 8 bits
    reset = 1; mode = 0; enable = 0; out_ready = 1;
    repeat (2) cycle();
    reset = 0; enable = 1; seen.delete();
    repeat (135) cycle();
    chk("prbs7_beat0", 32'(seen[0]), 32'h02);
    chk("prbs7_beat1", 32'(seen[1]), 32'h0C);
    chk("prbs7_beat127", 32'(seen[127]), 32'h02);
    chk("prbs7_beat128", 32'(seen[128]), 32'h0C);

    // Backpressure on PRBS13
    seed_load = 1; mode = 2; seed = 31'($urandom);
    cycle();
    seed_load = 0;
    repeat (10) cycle();
    out_ready = 0;
    repeat (5) cycle();
    out_ready = 1;
    repeat (10) cycle();

    // Zero seed on PRBS15 becomes all-ones
    seed_load = 1; mode = 3; seed = 31'd0;
    cycle();
    chk("zero_seed_flush", {31'd0, out_valid}, 32'd0);
    seed_load = 0; seen.delete();
    repeat (100) cycle();
    nz = 0;
    foreach (seen[i]) if (seen[i] != 0) nz++;
    chk("zero_seed_beats", 32'(seen.size()), 32'd100);
    chk("zero_seed_live", {31'd0, nz > 50}, 32'd1);
    chk("prbs15_beat0", 32'(seen[0]), 32'h00);
    chk("prbs15_beat1", 32'(seen[1]), 32'h02);

    // Illegal mode runs as PRBS31, then reset while stalled
    seed_load = 1; mode = 7; seed = 31'($urandom);
    cycle();
    chk("illegal_mode_err", {31'd0, mode_err}, 32'd1);
    seed_load = 0;
    repeat (50) begin
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    out_ready = 0;
    repeat (2) cycle();
    reset = 1; mode = 0;
    cycle();
    chk("reset_flush", {31'd0, out_valid}, 32'd0);
    chk("reset_mode_err", {31'd0, mode_err}, 32'd0);
    reset = 0; out_ready = 1; seen.delete();
    repeat (2) cycle();
    chk("restart_beat0", 32'(seen[0]), 32'h02);
    chk("restart_beat1", 32'(seen[1]), 32'h0C);

`ifdef PRBS_ERR_INJECT_EN
    // Two requests while stalled merge into one flipped beat
    reset = 1; mode = 1;
    cycle();
    reset = 0;
    repeat (3) cycle();
    out_ready = 0;
    err_inject = 1; cycle();
    err_inject = 0; cycle();
    err_inject = 1; cycle();
    err_inject = 0;
    repeat (2) cycle();
    out_ready = 1;
    repeat (4) cycle();
    chk("inject_count", {16'd0, err_count}, 32'd1);
    chk("inject_idle", {31'd0, err_pending}, 32'd0);
`endif

    // Randomised traffic
    repeat (1500) begin
      enable    = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      seed_load = ($urandom_range(0, 99) < 3);
      reset     = ($urandom_range(0, 99) < 1);
      mode      = 3'($urandom_range(0, 7));
      seed      = ($urandom_range(0, 3) == 0) ? 31'd0 : 31'($urandom);
`ifdef PRBS_ERR_INJECT_EN
      err_inject = ($urandom_range(0, 99) < 5);
`endif
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/prbs_gen_param.md
Name: prbs_gen_param

Overview:
- Parametrised, multi-polynomial PRBS pattern generator. Next generation of the team's fixed PRBS-13 LFSR.
- Emits DATA_W pattern bits per beat over a valid/ready stream interface.
- Polynomial is selectable at run time and the seed is loadable.
- Feeds the BERT transmit path and acts as the reference generator for the checker.

Parameters:
- DATA_W, 8, pattern bits produced per accepted beat (1..32).
- DEFAULT_SEED, 31'h7FFF_FFFF, seed loaded on reset, masked to the active polynomial order N.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  generator run enable.
- mode  in  3  polynomial select, latched on reset and on seed_load.
- seed_load  in  1  one-cycle pulse: latch mode and seed.
- seed  in  31  seed value, low N bits used.
- out_ready  in  1  downstream ready.
- out_valid  out  1  out_data valid.
- out_data  out  DATA_W  pattern bits; MSB is the earliest serial bit.
- mode_err  out  1  latched mode is illegal (6 or 7).

Behaviour:
- Modes (polynomial, order N):
  - 0 = PRBS7, x^7+x^6+1
  - 1 = PRBS9, x^9+x^5+1
  - 2 = PRBS13, x^13+x^12+x^2+x+1
  - 3 = PRBS15, x^15+x^14+1
  - 4 = PRBS23, x^23+x^18+1
  - 5 = PRBS31, x^31+x^28+1
  - 6 and 7 are illegal: they run as PRBS31 and set mode_err=1.
- State: 31-bit register; only bits [N-1:0] are used; upper bits are held at 0.
- One serial step:
  - f = XOR of state[e-1] for each non-constant exponent e.
  - state <= {state[N-2:0], f}.
  - Serial output bit = f.
- One beat = DATA_W serial steps, computed combinationally within one cycle. The first step's f lands in out_data[DATA_W-1].
- Reset (reset=1 at a clock edge):
  - state <= DEFAULT_SEED masked to N; N is taken from the mode port.
  - mode_reg <= mode.
  - out_valid <= 0, out_data <= 0, mode_err updated.
- Priority at each edge: reset > seed_load > advance > hold.
- seed_load:
  - mode_reg <= mode.
  - state <= seed masked to N. An all-zero masked seed is replaced by all-ones (lock-up avoidance).
  - out_valid <= 0: a pending beat is flushed without acceptance.
- Advance condition: enable && (!out_valid || out_ready). On advance:
  - out_data <= next beat.
  - state <= state after DATA_W steps.
  - out_valid <= 1.
- Drain: !enable && (!out_valid || out_ready) gives out_valid <= 0 and state holds.
- Hold: out_valid && !out_ready keeps out_data and state stable, whatever enable does.
- Latency: first valid beat appears one cycle after enable is first sampled high following reset or seed_load.
- Sustained throughput with out_ready=1: one beat per clock.
- Period: 2^N-1 serial bits. The state after k·(2^N-1) serial steps equals the seed.
- A mode change without seed_load or reset has no effect.

Optional Feature:
- Macro: PRBS_ERR_INJECT_EN.
- When defined, adds three ports:
  - err_inject  in  1: one-cycle request.
  - err_count  out  16: saturating count of injected errors; reset to 0.
  - err_pending  out  1: request waiting for a beat.
- Injection behaviour:
  - A request sets err_pending.
  - The next advance inverts out_data[DATA_W-1] of that beat, clears err_pending, and increments err_count (saturates at 16'hFFFF).
  - LFSR state is never affected.
  - Requests arriving while err_pending=1 merge into the pending one.
  - seed_load and reset clear err_pending.
- When undefined: ports absent, no inversion logic.

Test Plan:
- PRBS7 order: DATA_W=8, reset with mode=0, then enable=1, out_ready=1 → beats 8'h02, then 8'h0C.
- PRBS7 period: DATA_W=1, mode=0, seed_load seed=7'h7F → out_data sequence repeats with period 127. State equals 7'h7F after beat 127.
- Backpressure: mode=2, hold out_ready=0 for 5 cycles mid-stream → out_data stable and out_valid=1 throughout. The concatenated accepted stream is identical to the stream with no stalls.
- Zero seed: seed_load, mode=3, seed=0 → behaves as seed 15'h7FFF; out_valid=0 the cycle after the load; no lock-up over 100 beats.
- Illegal mode and reset mid-run: mode=7 → mode_err=1 and output matches mode=5. Reset asserted mid-beat with out_ready=0 → out_valid=0 next cycle, and the sequence restarts from DEFAULT_SEED.
- PRBS_ERR_INJECT_EN, two requests:
  - Pulse err_inject twice while out_ready=0 → exactly one beat with MSB flipped, err_count=1.
  - Next beat matches the reference model.
